mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a data port onto one memory command bus.
// Each accepted request takes three cycles: IDLE (accept), ISSUE (command driven
// to memory), RESP (memory result captured). The response registers load on the
// edge that leaves RESP, so rsp_valid is seen two edges after the accepting edge.
// When both ports contend, data wins until MAX_DATA_STREAK consecutive contended
// data grants have been made, after which a pending fetch wins once.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   if_req_valid/if_req_ready/if_addr fetch request (op fixed to LW)
//   if_rsp_valid/if_rsp_data/if_rsp_fault  fetch response, one-cycle pulse
//   d_req_valid/d_req_ready/d_op/d_addr/d_wdata  data request
//   d_rsp_valid/d_rsp_data/d_rsp_fault     data response, one-cycle pulse
//   mem_op/mem_addr/mem_in            registered command to the memory unit
//   mem_out/mem_fault                 memory result, valid the cycle after sampling
module mem_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_fault,

    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [2:0]  d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_fault,

    output logic [2:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    input  logic        mem_fault
);

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned OPW = 3;
    localparam int unsigned SW  = 4;

    localparam logic [OPW-1:0] OP_LW      = 3'b010;
    localparam logic [OPW-1:0] OP_IDLE    = 3'b000;
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic          owner_d;    // transaction in flight belongs to the data port
    logic          is_store;   // in-flight op is a store: response data forced to 0

    logic          accepting;
    logic          fetch_turn;
    logic          grant_f;
    logic          grant_d;
    logic [DW-1:0] rsp_data_c;

    // Grant decision; reset_n gates the readies so nothing is offered during reset.
    always_comb begin
        accepting  = (state == IDLE) && reset_n;
        fetch_turn = if_req_valid && (streak == STREAK_MAX);
        grant_f    = accepting && if_req_valid && (!d_req_valid || fetch_turn);
        grant_d    = accepting && d_req_valid && !fetch_turn;
    end

    assign if_req_ready = grant_f;
    assign d_req_ready  = grant_d;

    // Faulting ops and stores return zero data; loads pass the memory word through.
    assign rsp_data_c = (mem_fault || is_store) ? '0 : mem_out;

    // Arbiter FSM with registered command and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            streak       <= '0;
            owner_d      <= 1'b0;
            is_store     <= 1'b0;
            mem_op       <= OP_IDLE;
            mem_addr     <= '0;
            mem_in       <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            if_rsp_fault <= 1'b0;
            d_rsp_valid  <= 1'b0;
            d_rsp_data   <= '0;
            d_rsp_fault  <= 1'b0;
        end else begin
            // Responses are single-cycle pulses; only the RESP exit loads them.
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            if_rsp_fault <= 1'b0;
            d_rsp_valid  <= 1'b0;
            d_rsp_data   <= '0;
            d_rsp_fault  <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_f) begin
                        state    <= ISSUE;
                        owner_d  <= 1'b0;
                        is_store <= 1'b0;
                        streak   <= '0;
                        mem_op   <= OP_LW;
                        mem_addr <= if_addr;
                        mem_in   <= '0;
                    end else if (grant_d) begin
                        state    <= ISSUE;
                        owner_d  <= 1'b1;
                        is_store <= d_op[2];
                        mem_op   <= d_op;
                        mem_addr <= d_addr;
                        mem_in   <= d_wdata;
                        // Only contended data grants build the streak.
                        if (!if_req_valid) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + SW'(1);
                        end
                    end else begin
                        mem_op   <= OP_IDLE;
                        mem_addr <= AW'(0);
                        mem_in   <= DW'(0);
                    end
                end

                ISSUE: begin
                    // Memory samples the command on this edge; drop it so no store repeats.
                    state    <= RESP;
                    mem_op   <= OP_IDLE;
                    mem_addr <= AW'(0);
                    mem_in   <= DW'(0);
                end

                RESP: begin
                    state    <= IDLE;
                    mem_op   <= OP_IDLE;
                    mem_addr <= AW'(0);
                    mem_in   <= DW'(0);
                    if (owner_d) begin
                        d_rsp_valid  <= 1'b1;
                        d_rsp_data   <= rsp_data_c;
                        d_rsp_fault  <= mem_fault;
                    end else begin
                        if_rsp_valid <= 1'b1;
                        if_rsp_data  <= rsp_data_c;
                        if_rsp_fault <= mem_fault;
                    end
                end

                default: begin
                    state    <= IDLE;
                    mem_op   <= OP_IDLE;
                    mem_addr <= AW'(0);
                    mem_in   <= DW'(0);
                end
            endcase
        end
    end

endmodule
